tmr_fault_monitor: RTL and testbench

- Sequential consumer of the `err` outputs that the TMR pass attaches to every triplicated module's error-sink port (voter disagreement flags).
- Aggregates up to N_SINKS error lines, latches sticky per-sink flags and raises an interrupt.
- Runs a host-acknowledged scrub request/acknowledge handshake, escalating to a fatal state on handshake timeout.
- Sits directly downstream of the triplicated logic; it is not itself triplicated.

---
 rtl/tmr_fault_monitor.sv | 145 ++++++++++++++
 tb/tb_tmr_fault_monitor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_fault_monitor.sv
// Fault monitor fed by the voter error sinks of the triplicated logic: sticky flags,
// saturating rise counter, interrupt, and a host scrub handshake with timeout escalation.
module tmr_fault_monitor #(
    parameter int N_SINKS     = 3,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 16,
    parameter int COOL_CYCLES = 4,
    localparam int FIRST_W    = (N_SINKS > 1) ? $clog2(N_SINKS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SINKS-1:0] err_in,
    input  logic               clr,
    output logic               scrub_req,
    input  logic               scrub_ack,
    output logic               irq,
    output logic               fatal,
    output logic [N_SINKS-1:0] fault_vec,
    output logic [FIRST_W-1:0] first_idx,
    output logic [CNT_W-1:0]   fault_count,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REPORT   = 3'd1,
        S_SCRUB    = 3'd2,
        S_COOLDOWN = 3'd3,
        S_FATAL    = 3'd4
    } state_t;

    localparam int TMR_MAX = (TIMEOUT > COOL_CYCLES) ? TIMEOUT : COOL_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SCRUB_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] COOL_LAST  = TMR_W'(COOL_CYCLES - 1);

    state_t             state_q;
    logic               err_prev_q;
    logic [TMR_W-1:0]   timer_q;
    logic               irq_q;
    logic               scrub_req_q;
    logic               fatal_q;
    logic [N_SINKS-1:0] fault_vec_q;
    logic [FIRST_W-1:0] first_idx_q;
    logic [CNT_W-1:0]   fault_count_q;

    logic               err_any;
    logic               rise;
    logic [CNT_W-1:0]   fault_count_d;
    logic [N_SINKS-1:0] fault_vec_d;

    function automatic logic [FIRST_W-1:0] lowest_set(input logic [N_SINKS-1:0] v);
        lowest_set = '0;
        for (int i = N_SINKS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = FIRST_W'(i);
        end
    endfunction

    always_comb begin
        err_any       = |err_in;
        rise          = err_any & ~err_prev_q;
        fault_count_d = fault_count_q;
        if (rise && (fault_count_q != {CNT_W{1'b1}})) fault_count_d = fault_count_q + CNT_W'(1);
        fault_vec_d   = fault_vec_q | err_in;
    end

    // Scrub handshake: scrub_req holds high while in SCRUB; a scrub_ack sampled high on a
    // rising edge with scrub_req=1 completes the transfer. scrub_ack at any other time is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            err_prev_q    <= 1'b0;
            timer_q       <= '0;
            irq_q         <= 1'b0;
            scrub_req_q   <= 1'b0;
            fatal_q       <= 1'b0;
            fault_vec_q   <= '0;
            first_idx_q   <= '0;
            fault_count_q <= '0;
        end else begin
            err_prev_q    <= err_any;
            fault_count_q <= fault_count_d;
            fault_vec_q   <= fault_vec_d;
            case (state_q)
                S_IDLE: begin
                    if (err_any) begin
                        state_q     <= S_REPORT;
                        first_idx_q <= lowest_set(err_in);
                        irq_q       <= 1'b1;
                    end
                end
                S_REPORT: begin
                    if (clr) begin
                        // Reload rather than clear so errors present on the accept cycle survive.
                        state_q     <= S_SCRUB;
                        timer_q     <= '0;
                        fault_vec_q <= err_in;
                        irq_q       <= 1'b0;
                        scrub_req_q <= 1'b1;
                    end
                end
                S_SCRUB: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (scrub_ack) begin
                        state_q     <= S_COOLDOWN;
                        timer_q     <= '0;
                        scrub_req_q <= 1'b0;
                    end else if (timer_q == SCRUB_LAST) begin
                        state_q     <= S_FATAL;
                        scrub_req_q <= 1'b0;
                        irq_q       <= 1'b1;
                        fatal_q     <= 1'b1;
                    end
                end
                S_COOLDOWN: begin
                    if (timer_q == COOL_LAST) begin
                        if (fault_vec_q != '0) begin
                            state_q     <= S_REPORT;
                            first_idx_q <= lowest_set(fault_vec_q);
                            irq_q       <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_FATAL: begin
                    irq_q   <= 1'b1;
                    fatal_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign scrub_req   = scrub_req_q;
    assign irq         = irq_q;
    assign fatal       = fatal_q;
    assign fault_vec   = fault_vec_q;
    assign first_idx   = first_idx_q;
    assign fault_count = fault_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed plus randomized bench for tmr_fault_monitor with default parameters.
module tb_tmr_fault_monitor;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_REPORT = 3'd1, ST_SCRUB = 3'd2, ST_COOL = 3'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] err_in;
  logic       clr;
  logic       scrub_req;
  logic       scrub_ack;
  logic       irq;
  logic       fatal;
  logic [2:0] fault_vec;
  logic [1:0] first_idx;
  logic [7:0] fault_count;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  // reference model: counts rises of the aggregate error level, ORs flags since last accept
  int         m_count;
  logic [2:0] m_vec;
  logic       m_prev;
  logic       clr_accept;

  tmr_fault_monitor dut (
    .clk(clk), .rst(rst), .err_in(err_in), .clr(clr), .scrub_req(scrub_req),
    .scrub_ack(scrub_ack), .irq(irq), .fatal(fatal), .fault_vec(fault_vec),
    .first_idx(first_idx), .fault_count(fault_count), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic int lowest(input logic [2:0] v);
    logic [2:0] iso;
    iso = v & (~v + 3'd1);
    return $clog2(iso);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: advance one clock, updating the model with the inputs sampled at that edge
  task automatic tick();
    if (rst) begin
      m_count = 0;
      m_vec   = 3'b000;
      m_prev  = 1'b0;
    end else begin
      if ((err_in != 3'b000) && !m_prev && m_count < 255) m_count++;
      m_prev = (err_in != 3'b000);
      m_vec  = clr_accept ? err_in : (m_vec | err_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_vec"}, 32'(fault_vec), 32'(m_vec));
    chk({tag, "_count"}, 32'(fault_count), 32'(m_count));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_irq"}, 32'(irq), 0);
    chk({tag, "_sreq"}, 32'(scrub_req), 0);
    chk({tag, "_fatal"}, 32'(fatal), 0);
    chk({tag, "_vec"}, 32'(fault_vec), 0);
    chk({tag, "_first"}, 32'(first_idx), 0);
    chk({tag, "_count"}, 32'(fault_count), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic accept_clr();
    clr = 1'b1;
    clr_accept = 1'b1;
    tick();
    clr = 1'b0;
    clr_accept = 1'b0;
  endtask

  initial begin
    int n;
    logic [2:0] first_vec;
    logic       seen;
    rst = 1'b0; err_in = 3'b000; clr = 1'b0; scrub_ack = 1'b0; clr_accept = 1'b0;
    m_count = 0; m_vec = 3'b000; m_prev = 1'b0;

    // reset state
    do_reset();
    chk_zero("reset");
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // single pulse on sink 2
    err_in = 3'b100;
    tick();
    err_in = 3'b000;
    chk("pulse_irq", 32'(irq), 1);
    chk("pulse_first", 32'(first_idx), 2);
    chk("pulse_sreq", 32'(scrub_req), 0);
    chk_model("pulse");
    chk("pulse_vec_lit", 32'(fault_vec), 32'(3'b100));
    chk("pulse_count_lit", 32'(fault_count), 1);

    // scrub acknowledged on the third request cycle
    accept_clr();
    for (int i = 0; i < 3; i++) begin
      chk("ack3_sreq", 32'(scrub_req), 1);
      chk("ack3_irq", 32'(irq), 0);
      scrub_ack = (i == 2);
      tick();
    end
    scrub_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("cool_state", 32'(dbg_state), 32'(ST_COOL));
      chk("cool_sreq", 32'(scrub_req), 0);
      chk("cool_irq", 32'(irq), 0);
      tick();
    end
    chk("cool_exit_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("cool_exit_vec", 32'(fault_vec), 0);
    chk_model("ack3");

    // timeout to FATAL
    err_in = 3'b010;
    tick();
    err_in = 3'b000;
    chk("to_first", 32'(first_idx), 1);
    accept_clr();
    n = 0;
    while (scrub_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_sreq_len", 32'(n), 16);
    chk("to_fatal", 32'(fatal), 1);
    chk("to_irq", 32'(irq), 1);
    for (int i = 0; i < 100; i++) begin
      clr    = (i % 10 == 0);
      err_in = (i % 25 == 3) ? 3'($urandom_range(1, 7)) : 3'b000;
      tick();
      if (i % 10 == 0) begin
        chk("fatal_hold", 32'(fatal), 1);
        chk("fatal_irq_hold", 32'(irq), 1);
        chk("fatal_sreq", 32'(scrub_req), 0);
      end
    end
    clr = 1'b0; err_in = 3'b000;
    tick();
    chk_model("fatal");
    do_reset();
    chk_zero("fatal_rst");

    // level held 50 cycles counts once
    err_in = 3'b001;
    for (int i = 0; i < 50; i++) tick();
    chk("held_count", 32'(fault_count), 1);
    chk("held_state", 32'(dbg_state), 32'(ST_REPORT));
    err_in = 3'b000;
    tick();
    accept_clr();
    scrub_ack = 1'b1;
    tick();
    scrub_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("held_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk_model("held");

    // simultaneous errors: lowest index wins, one rise
    err_in = 3'b110;
    tick();
    err_in = 3'b000;
    chk("simul_first", 32'(first_idx), 1);
    chk_model("simul");

    // ack on the last permitted scrub cycle
    tick();
    accept_clr();
    for (int i = 0; i < 15; i++) tick();
    chk("ack16_sreq", 32'(scrub_req), 1);
    scrub_ack = 1'b1;
    tick();
    scrub_ack = 1'b0;
    chk("ack16_state", 32'(dbg_state), 32'(ST_COOL));
    chk("ack16_fatal", 32'(fatal), 0);
    chk("ack16_sreq_low", 32'(scrub_req), 0);

    // error during COOLDOWN re-enters REPORT on exit
    tick();
    err_in = 3'b001;
    tick();
    err_in = 3'b000;
    tick();
    chk("cderr_still_cool", 32'(dbg_state), 32'(ST_COOL));
    tick();
    chk("cderr_state", 32'(dbg_state), 32'(ST_REPORT));
    chk("cderr_irq", 32'(irq), 1);
    chk("cderr_first", 32'(first_idx), 0);
    chk_model("cderr");

    // reset in the middle of a scrub
    accept_clr();
    tick();
    chk("rstscrub_pre", 32'(scrub_req), 1);
    do_reset();
    chk_zero("rstscrub");

    // saturation: 300 separate random pulses
    for (int i = 0; i < 300; i++) begin
      err_in = 3'($urandom_range(1, 7));
      tick();
      err_in = 3'b000;
      tick();
    end
    chk("sat_count", 32'(fault_count), 255);
    chk_model("sat");
    do_reset();

    // random bursts with random gaps against the model
    seen = 1'b0;
    first_vec = 3'b000;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        err_in = 3'($urandom_range(1, 7));
        if (!seen) begin
          first_vec = err_in;
          seen = 1'b1;
        end
        tick();
      end
      err_in = 3'b000;
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) tick();
    end
    tick();
    chk("rand_first", 32'(first_idx), 32'(lowest(first_vec)));
    chk("rand_irq", 32'(irq), 1);
    chk_model("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
